// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } uart_state_e;

    localparam int DATA_BITS    = 8;
    localparam int CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running bit-period strobe generator for uart_rx
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    output logic baud_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // The tick is registered on the wrap so it lands exactly CLKS_PER_BIT clocks apart.
    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = 1'b0;
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign baud_tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 1x-sampled UART receiver; even parity stage present when UART_RX_PARITY_EN is defined
module uart_rx
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 baud_tick,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 p_err,
    output logic                 rx_valid,
    output logic                 f_err
);

    localparam int CNT_W = $clog2(DATA_BITS);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 p_err_q, p_err_d;
    logic                 f_err_q, f_err_d;
    logic                 valid_q, valid_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        p_err_d   = p_err_q;
        f_err_d   = f_err_q;
        valid_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    // No mid-bit recheck: any low sample is taken as a start bit.
                    if (!rx) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {rx, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    par_bad_d = (^shift_q) ^ rx;
                    state_d   = STOP;
                end
`endif
                STOP: begin
                    data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
                    p_err_d = par_bad_q;
`else
                    p_err_d = 1'b0;
`endif
                    f_err_d = ~rx;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            p_err_q   <= 1'b0;
            f_err_q   <= 1'b0;
            valid_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            p_err_q   <= p_err_d;
            f_err_q   <= f_err_d;
            valid_q   <= valid_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign data_out = data_q;
    assign p_err    = p_err_q;
    assign f_err    = f_err_q;
    assign rx_valid = valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx driven by uart_baud_gen
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       baud_tick;
    logic [7:0] data_out;
    logic       p_err, f_err, rx_valid;

    int vectors     = 0;
    int miscompares = 0;
    int valid_cnt   = 0;

    always #10 clk = ~clk;

    uart_baud_gen #(.CLKS_PER_BIT(16)) u_baud (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick)
    );

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .baud_tick (baud_tick),
        .data_out  (data_out),
        .p_err     (p_err),
        .rx_valid  (rx_valid),
        .f_err     (f_err)
    );

    always @(negedge clk) if (rx_valid === 1'b1) valid_cnt++;

    // Returns 1 ns after the clock edge on which the DUT samples rx.
    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (baud_tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (baud_tick !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL tick_timeout: baud_tick=%b after %0d clks, required 1", baud_tick, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input bit stp, input string name);
        logic bits[$];
        bit   early = 1'b0;
        int   c0;
        logic exp_p = 1'b0;
        logic exp_f;
        bits = {1'b0};
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_RX_PARITY_EN
        bits.push_back(par);
        exp_p = (($countones(d) + int'(par)) % 2) == 1;
`endif
        bits.push_back(stp);
        exp_f = ~stp;
        c0 = valid_cnt;
        for (int i = 0; i < bits.size(); i++) begin
            rx = bits[i];
            wait_tick();
            if (i < bits.size() - 1 && rx_valid === 1'b1) early = 1'b1;
        end
        vectors++;
        if (rx_valid !== 1'b1 || early) begin
            miscompares++;
            $display("FAIL %s_latency: rx_valid=%b early=%b, required 1 on tick %0d only", name, rx_valid, early, bits.size());
        end
        vectors++;
        if ({data_out, p_err, f_err} !== {d, exp_p, exp_f}) begin
            miscompares++;
            $display("FAIL %s_data: data_out=%h p_err=%b f_err=%b, required %h %b %b", name, data_out, p_err, f_err, d, exp_p, exp_f);
        end
        rx = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (valid_cnt - c0 !== 1 || rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_pulse: pulses=%0d rx_valid_now=%b, required 1 pulse then 0", name, valid_cnt - c0, rx_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({data_out, p_err, f_err, rx_valid, baud_tick} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: data_out=%h p_err=%b f_err=%b rx_valid=%b tick=%b, required all 0", data_out, p_err, f_err, rx_valid, baud_tick);
        end
        rst = 1'b0;
    endtask

    task automatic test_baud_gen();
        int n;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (baud_tick !== 1'b1 && n < 40);
        vectors++;
        if (n !== 16) begin
            miscompares++;
            $display("FAIL baud_first_tick: %0d clks, required 16", n);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (baud_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL baud_width: tick=%b one clk later, required 0", baud_tick);
        end
        n = 1;
        while (baud_tick !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (n !== 16) begin
            miscompares++;
            $display("FAIL baud_period: %0d clks, required 16", n);
        end
    endtask

    task automatic test_good_frame();
        send_frame(8'hAB, 1'b1, 1'b1, "good_ab");
    endtask

    task automatic test_parity_error();
        send_frame(8'hAB, 1'b0, 1'b1, "parity_ab");
    endtask

    task automatic test_framing();
        int c0;
        send_frame(8'h00, 1'b0, 1'b0, "framing_00");
        c0 = valid_cnt;
        repeat (13) wait_tick();
        vectors++;
        if (valid_cnt !== c0) begin
            miscompares++;
            $display("FAIL framing_idle: %0d pulses on idle line, required 0", valid_cnt - c0);
        end
        send_frame(8'h96, 1'b0, 1'b1, "after_framing");
    endtask

    task automatic test_back_to_back();
        send_frame(8'h55, 1'b0, 1'b1, "b2b_55");
        send_frame(8'h3C, 1'b0, 1'b1, "b2b_3c");
    endtask

    task automatic test_reset_midframe();
        int c0;
        rx = 1'b0;
        wait_tick();
        for (int i = 0; i < 4; i++) begin
            rx = (8'hF0 >> i) & 1'b1;
            wait_tick();
        end
        c0 = valid_cnt;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        rx = 1'b1;
        repeat (12) wait_tick();
        vectors++;
        if (valid_cnt !== c0 || data_out !== 8'h00 || p_err !== 1'b0 || f_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_reset: pulses=%0d data_out=%h p_err=%b f_err=%b, required 0 00 0 0", valid_cnt - c0, data_out, p_err, f_err);
        end
        send_frame(8'hA5, 1'b0, 1'b1, "after_reset");
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit par, stp;
        for (int k = 0; k < 20; k++) begin
            d   = 8'($urandom);
            par = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
            stp = $urandom_range(0, 3) != 0;
            send_frame(d, par, stp, $sformatf("rand%0d", k));
            repeat ($urandom_range(0, 2)) wait_tick();
        end
    endtask

    initial begin
        test_reset();
        test_baud_gen();
        test_good_frame();
        test_parity_error();
        test_framing();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
